// File: rtl/relu_maxpool_pkg.sv
// Shared definitions for the ReLU + 2x2 max-pool stage: FSM encoding, default width
// and a signed-max helper reused by other pool stages.
package relu_maxpool_pkg;

    localparam int DEFAULT_BIT_DEPTH = 8;

    // smax works on a wide signed word so any BIT_DEPTH up to SMAX_W can share it.
    localparam int SMAX_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROW_EVEN = 3'd1,
        ROW_ODD  = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } state_t;

    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/relu_maxpool_pool_line_buf.sv
// Line buffer holding one horizontal-max value per column pair of the even row.
// Not reset: every entry is written in ROW_EVEN before ROW_ODD reads it.
module pool_line_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/relu_maxpool.sv
// ReLU + 2x2/stride-2 max-pool on {sum1,sum2} pairs from the conv engine.
// Define POOL_RELU_EN to clamp negatives to zero before pooling.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// A valid is never withdrawn before its transfer, and its data stays stable until then.
module relu_maxpool
    import relu_maxpool_pkg::*;
#(
    parameter int BIT_DEPTH = DEFAULT_BIT_DEPTH,
    parameter int OUT_W     = 8,
    parameter int OUT_H     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_DEPTH-1:0] sum1,
    input  logic [BIT_DEPTH-1:0] sum2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_DEPTH-1:0] out_data,
    output logic                 busy,
    output logic                 done,
    output state_t               fsm_state
);

    localparam int PAIRS = OUT_W / 2;
    localparam int COL_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int ROW_W = $clog2(OUT_H);

    state_t state, state_nx;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic             accept;
    logic             last_col;
    logic             last_row;
    logic             buf_we;
    logic             load;

    logic [BIT_DEPTH-1:0]        act1, act2;
    logic signed [BIT_DEPTH-1:0] act1_s, act2_s, lb_s;
    logic signed [SMAX_W-1:0]    hmax_ext, pool_ext;
    logic [BIT_DEPTH-1:0]        hmax, pool, lb_rdata;
    logic                        unused_hi;

    function automatic logic [BIT_DEPTH-1:0] activate(input logic [BIT_DEPTH-1:0] x);
`ifdef POOL_RELU_EN
        return x[BIT_DEPTH-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    assign last_col = (col_cnt == COL_W'(PAIRS - 1));
    assign last_row = (row_cnt == ROW_W'(OUT_H - 1));
    assign accept   = in_valid && in_ready;
    assign buf_we   = accept && (state == ROW_EVEN);
    assign load     = accept && (state == ROW_ODD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = ROW_EVEN;
            end
            ROW_EVEN: begin
                in_ready = 1'b1;
                if (in_valid && last_col) state_nx = ROW_ODD;
            end
            ROW_ODD: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready && last_col) begin
                    state_nx = last_row ? DRAIN : ROW_EVEN;
                end
            end
            // Leave as soon as the output register will be empty next cycle,
            // so done lands the cycle after the final output handshake.
            DRAIN: begin
                if (!out_valid || out_ready) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_cnt <= '0;
                row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        act1     = activate(sum1);
        act2     = activate(sum2);
        act1_s   = act1;
        act2_s   = act2;
        hmax_ext = smax(SMAX_W'(act1_s), SMAX_W'(act2_s));
        hmax     = hmax_ext[BIT_DEPTH-1:0];
        lb_s     = lb_rdata;
        pool_ext = smax(SMAX_W'(lb_s), hmax_ext);
        pool     = pool_ext[BIT_DEPTH-1:0];
    end

    assign unused_hi = ^{hmax_ext[SMAX_W-1:BIT_DEPTH], pool_ext[SMAX_W-1:BIT_DEPTH]};

    pool_line_buf #(
        .DEPTH(PAIRS),
        .WIDTH(BIT_DEPTH),
        .AW   (COL_W)
    ) u_line_buf (
        .clk  (clk),
        .we   (buf_we),
        .addr (col_cnt),
        .wdata(hmax),
        .rdata(lb_rdata)
    );

    // A reload in the same cycle as a drain keeps out_valid high: 1 pixel/cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= pool;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy      = (state == ROW_EVEN) || (state == ROW_ODD);
    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_relu_maxpool.sv
// Bench for relu_maxpool (OUT_W=4, OUT_H=2): directed frames, scoreboard queue and
// a negedge monitor that pops and compares each output handshake.
module tb_relu_maxpool;
    import relu_maxpool_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sum1;
    logic [7:0] sum2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
    state_t     fsm_state;

    relu_maxpool #(
        .BIT_DEPTH(8),
        .OUT_W    (4),
        .OUT_H    (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum1     (sum1),
        .sum2     (sum2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .done     (done),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_cyc   = -10;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    // Per frame: row0 pair0, row0 pair1, row1 pair0, row1 pair1, as (sum1,sum2).
    int         vec   [3][8];
    logic [7:0] exp_t [3][2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_data), 32'hDEAD);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check("done_latency", 32'(cyc), 32'(hs_cyc + 1));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int a, input int b);
        int n;
        in_valid = 1'b1;
        sum1 = 8'(a);
        sum2 = 8'(b);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!done) check("done_timeout", 32'(done), 32'h1);
    endtask

    task automatic backpressure_phase(input logic [7:0] held);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'h0);
            check("bp_out_data_hold", 32'(out_data), 32'(held));
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic run_frame(input int f, input bit bp, input bit restart);
        int d0;
        d0 = done_cnt;
        exp_q.push_back(exp_t[f][0]);
        exp_q.push_back(exp_t[f][1]);
        pulse_start();
        if (bp) out_ready = 1'b0;
        fork
            begin
                for (int p = 0; p < 4; p++) begin
                    send(vec[f][2*p], vec[f][2*p+1]);
                    if (restart && p == 2) pulse_start();
                end
            end
            begin
                if (bp) backpressure_phase(exp_t[f][0]);
            end
        join
        wait_done();
        repeat (3) @(negedge clk);
        check("idle_after_frame_busy", 32'(busy), 32'h0);
        check("done_pulses", 32'(done_cnt - d0), 32'h1);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        vec = '{'{1, 5, 2, 3, 4, 0, 9, 7},
                '{-3, -8, -1, -2, -5, -4, -7, -6},
                '{127, -128, 0, 0, 100, 120, 0, 0}};
        exp_t[0][0] = 8'd5;
        exp_t[0][1] = 8'd9;
`ifdef POOL_RELU_EN
        exp_t[1][0] = 8'h00;
        exp_t[1][1] = 8'h00;
`else
        exp_t[1][0] = 8'hFD;
        exp_t[1][1] = 8'hFF;
`endif
        exp_t[2][0] = 8'd127;
        exp_t[2][1] = 8'd0;

        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        sum1      = '0;
        sum2      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset mid-ROW_ODD with the first window result pending
        begin
            int d0;
            d0 = done_cnt;
            pulse_start();
            send(vec[0][0], vec[0][1]);
            send(vec[0][2], vec[0][3]);
            send(vec[0][4], vec[0][5]);
            #1 rst_n = 1'b0;
            #1;
            check("midrst_out_valid", 32'(out_valid), 32'h0);
            check("midrst_busy", 32'(busy), 32'h0);
            check("midrst_done", 32'(done), 32'h0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            repeat (2) @(posedge clk); #1;
            check("midrst_no_done", 32'(done_cnt - d0), 32'h0);
        end

        run_frame(0, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b0);
        run_frame(0, 1'b1, 1'b0);
        run_frame(0, 1'b0, 1'b1);
        run_frame(2, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
